// File: rtl/seg7_digit_scroller_if.sv
// Byte-to-display bus between the CPU output register and the
// single-digit decimal scroller.
interface seg7_digit_scroller_if;
  logic [7:0] value_in;
  logic       value_load;
  logic       signed_mode;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [1:0] digit_idx;
  logic       busy;

  modport master (
    output value_in, value_load, signed_mode,
    input  seg_out, dp_out, digit_idx, busy
  );

  modport slave (
    input  value_in, value_load, signed_mode,
    output seg_out, dp_out, digit_idx, busy
  );
endinterface

// File: rtl/seg7_digit_scroller.sv
// Renders each captured byte as decimal on one 7-segment digit:
// serial double-dabble, then sign/hundreds/tens/ones scrolled in turn.
module seg7_digit_scroller #(
  parameter logic [23:0] DWELL_CYCLES = 24'd10_000_000,
  parameter logic [23:0] BLANK_CYCLES = 24'd2_500_000,
  parameter bit          COMMON_ANODE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_digit_scroller_if.slave  io
);

  typedef enum logic [1:0] {
    IDLE, CONVERT, SHOW, GAP
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  pend_q, pend_d;
  logic        pvld_q, pvld_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic        neg_q, neg_d;
  logic [1:0]  idx_q, idx_d;

  logic        start, direct, adv;
  logic [8:0]  src;
  logic [7:0]  mag;
  logic [19:0] dd;
  logic [6:0]  seg_raw;
  logic        dp_raw;

  function automatic logic [3:0] adj3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [11:0] dd_adj(
    input logic [11:0] b
  );
    return {adj3(b[11:8]), adj3(b[7:4]),
            adj3(b[3:0])};
  endfunction

  // Leading zeros: hundreds dropped if 0,
  // tens dropped only if hundreds also 0.
  function automatic logic [1:0] next_idx(
    input logic [1:0]  cur,
    input logic [11:0] b
  );
    logic [1:0] r;
    r = 2'd0;
    unique case (1'b1)
      (cur == 2'd3): begin
        if (b[11:8] != 4'd0)     r = 2'd2;
        else if (b[7:4] != 4'd0) r = 2'd1;
        else                     r = 2'd0;
      end
      (cur == 2'd2): r = 2'd1;
      default:       r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] first_idx(
    input logic        neg,
    input logic [11:0] b
  );
    return neg ? 2'd3 : next_idx(2'd3, b);
  endfunction

  function automatic logic [6:0] enc(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pvld_d  = pvld_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    idx_d   = idx_q;
    start   = 1'b0;
    direct  = 1'b0;
    adv     = 1'b0;
    src     = pend_q;
    mag     = 8'd0;
    dd      = 20'd0;

    unique case (state_q)
      IDLE: begin
        if (pvld_q) start = 1'b1;
      end
      CONVERT: begin
        if (cnt_q == 24'd8) begin
          cnt_d   = 24'd0;
          state_d = SHOW;
          idx_d   = first_idx(neg_q, bcd_q);
        end else begin
          dd    = {dd_adj(bcd_q), bin_q} << 1;
          bcd_d = dd[19:8];
          bin_d = dd[7:0];
          cnt_d = cnt_q + 24'd1;
        end
      end
      SHOW: begin
        if (cnt_q == DWELL_CYCLES - 24'd1) begin
          cnt_d = 24'd0;
          if (BLANK_CYCLES == 24'd0) adv = 1'b1;
          else state_d = GAP;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      GAP: begin
        if (cnt_q == BLANK_CYCLES - 24'd1) begin
          cnt_d = 24'd0;
          adv   = 1'b1;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
    endcase

    if (adv) begin
      if (idx_q == 2'd0) begin
        if (io.value_load) begin
          start  = 1'b1;
          direct = 1'b1;
        end else if (pvld_q) begin
          start = 1'b1;
        end else begin
          state_d = SHOW;
          idx_d   = first_idx(neg_q, bcd_q);
        end
      end else begin
        state_d = SHOW;
        idx_d   = next_idx(idx_q, bcd_q);
      end
    end

    if (start) begin
      if (direct)
        src = {io.signed_mode, io.value_in};
      mag     = (src[8] & src[7]) ?
                (8'd0 - src[7:0]) : src[7:0];
      state_d = CONVERT;
      cnt_d   = 24'd0;
      neg_d   = src[8] & src[7];
      bin_d   = mag;
      bcd_d   = 12'd0;
      pvld_d  = 1'b0;
    end

    // A load consumed directly at sequence end is not re-queued.
    if (io.value_load && !direct) begin
      pend_d = {io.signed_mode, io.value_in};
      pvld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 9'd0;
      pvld_q  <= 1'b0;
      cnt_q   <= 24'd0;
      bin_q   <= 8'd0;
      bcd_q   <= 12'd0;
      neg_q   <= 1'b0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    seg_raw = 7'h00;
    dp_raw  = 1'b0;
    if (state_q == SHOW) begin
      dp_raw = (idx_q == 2'd0);
      unique case (idx_q)
        2'd3: seg_raw = 7'h40;
        2'd2: seg_raw = enc(bcd_q[11:8]);
        2'd1: seg_raw = enc(bcd_q[7:4]);
        2'd0: seg_raw = enc(bcd_q[3:0]);
      endcase
    end
  end

  assign io.seg_out   = COMMON_ANODE ? ~seg_raw : seg_raw;
  assign io.dp_out    = COMMON_ANODE ? ~dp_raw : dp_raw;
  assign io.digit_idx = idx_q;
  assign io.busy      = (state_q == CONVERT);

endmodule

// File: tb/tb_seg7_digit_scroller.sv
// Directed scoreboard bench for seg7_digit_scroller:
// expected digit sequences are queued per load and popped per lit digit.
module tb_seg7_digit_scroller;

  localparam int DW = 4;
  localparam int BL = 2;
  localparam logic [6:0] ENC [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
  } ent_t;

  logic clk;
  logic rst_n;
  seg7_digit_scroller_if bus ();

  seg7_digit_scroller #(
    .DWELL_CYCLES (24'd4),
    .BLANK_CYCLES (24'd2),
    .COMMON_ANODE (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         pop_n = 0;
  int         inj_pop = -1;
  int         inj_kind = 0;
  logic [7:0] inj_v = 8'd0;
  logic       inj_s = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_number(input int v, input bit s);
    bit neg;
    int mag, h, t, o;
    neg = s && (v >= 128);
    mag = neg ? 256 - v : v;
    h = mag / 100;
    t = (mag / 10) % 10;
    o = mag % 10;
    if (neg) q.push_back('{7'h40, 1'b0, 2'd3});
    if (h != 0) q.push_back('{ENC[h], 1'b0, 2'd2});
    if (h != 0 || t != 0)
      q.push_back('{ENC[t], 1'b0, 2'd1});
    q.push_back('{ENC[o], 1'b1, 2'd0});
  endtask

  task automatic arm(input int at, input int kind,
                     input logic [7:0] v, input logic s);
    inj_pop  = at;
    inj_kind = kind;
    inj_v    = v;
    inj_s    = s;
  endtask

  task automatic drive_load(input logic [7:0] v,
                            input logic s);
    bus.value_in    = v;
    bus.signed_mode = s;
    bus.value_load  = 1'b1;
  endtask

  // Entered on the first lit cycle; returns on the cycle after the gap.
  task automatic show_digit(input ent_t e, input int kind);
    chk("seg", {25'd0, bus.seg_out}, {25'd0, e.seg});
    chk("dp", {31'd0, bus.dp_out}, {31'd0, e.dp});
    chk("idx", {30'd0, bus.digit_idx}, {30'd0, e.idx});
    if (kind == 1) drive_load(inj_v, inj_s);
    for (int i = 1; i < DW; i++) begin
      @(negedge clk);
      if (kind == 1 && i == 1) bus.value_load = 1'b0;
      chk("dwell", {25'd0, bus.seg_out}, {25'd0, e.seg});
    end
    for (int j = 0; j < BL; j++) begin
      @(negedge clk);
      chk("gap_seg", {25'd0, bus.seg_out}, 32'd0);
      chk("gap_idx", {30'd0, bus.digit_idx},
          {30'd0, e.idx});
      if (kind == 2 && j == BL - 1)
        drive_load(inj_v, inj_s);
    end
    @(negedge clk);
    if (kind == 2) bus.value_load = 1'b0;
  endtask

  task automatic drain(input int n);
    ent_t e;
    int   k;
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL queue: observed empty expected entry");
        return;
      end
      e = q.pop_front();
      pop_n++;
      k = (pop_n == inj_pop) ? inj_kind : 0;
      show_digit(e, k);
    end
  endtask

  task automatic wait_convert();
    for (int i = 0; i < 9; i++) begin
      chk("busy", {31'd0, bus.busy}, 32'd1);
      chk("cv_seg", {25'd0, bus.seg_out}, 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_seg"}, {25'd0, bus.seg_out}, 32'd0);
      chk({tag, "_dp"}, {31'd0, bus.dp_out}, 32'd0);
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, "_idx"}, {30'd0, bus.digit_idx}, 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic load_from_idle(input logic [7:0] v,
                                input logic s);
    drive_load(v, s);
    @(negedge clk);
    bus.value_load = 1'b0;
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    wait_convert();
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.value_in    = 8'd0;
    bus.value_load  = 1'b0;
    bus.signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    idle_check(1, "rst");
    rst_n = 1'b1;
    @(negedge clk);
    idle_check(20, "noload");

    // 7 loops; equal reload restarts conversion, then 205 injected
    load_from_idle(8'd7, 1'b0);
    repeat (3) push_number(7, 1'b0);
    arm(pop_n + 3, 1, 8'd7, 1'b0);
    drain(3);
    wait_convert();
    push_number(7, 1'b0);
    arm(pop_n + 1, 1, 8'd205, 1'b0);
    drain(1);
    wait_convert();

    // 205, then -128 loaded on the final gap edge
    push_number(205, 1'b0);
    push_number(205, 1'b0);
    arm(pop_n + 6, 2, 8'h80, 1'b1);
    drain(6);
    wait_convert();

    push_number(128, 1'b1);
    push_number(128, 1'b1);
    arm(pop_n + 5, 1, 8'hFF, 1'b1);
    drain(8);
    wait_convert();

    push_number(255, 1'b1);
    push_number(255, 1'b1);
    arm(pop_n + 3, 1, 8'd42, 1'b0);
    drain(4);
    wait_convert();

    // 9 arrives while '4' lit; 42 must finish once only
    push_number(42, 1'b0);
    arm(pop_n + 1, 1, 8'd9, 1'b0);
    drain(2);
    wait_convert();
    repeat (3) push_number(9, 1'b0);
    drain(3);

    // async reset mid-SHOW drops a pending value
    drive_load(8'd200, 1'b0);
    @(negedge clk);
    bus.value_load = 1'b0;
    chk("pre_rst_seg", {25'd0, bus.seg_out},
        {25'd0, ENC[9]});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_seg", {25'd0, bus.seg_out}, 32'd0);
    chk("async_dp", {31'd0, bus.dp_out}, 32'd0);
    chk("async_idx", {30'd0, bus.digit_idx}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_check(30, "postrst");

    load_from_idle(8'd0, 1'b0);
    push_number(0, 1'b0);
    push_number(0, 1'b0);
    drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
